apb_to_axi_master: RTL

Bridge that accepts single APB transfers and completes each as one single-beat AXI4 transaction on a 64-bit AXI master port. It is the inverse of the SoC peripheral AXI-to-APB path. APB-side agents use it, for example debug or a boot controller, to reach the SoC AXI crossbar. Strictly one outstanding transfer; APB `pready` is held low until the AXI response arrives.

---
 rtl/apb_to_axi_master_pkg.sv | 43 ++++
 rtl/apb_to_axi_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_axi_master_pkg.sv
// Shared AXI field widths, encodings and helpers for the APB-to-AXI master bridge.
package apb_to_axi_master_pkg;

    localparam int unsigned AXI_LEN_W    = 8;
    localparam int unsigned AXI_SIZE_W   = 3;
    localparam int unsigned AXI_BURST_W  = 2;
    localparam int unsigned AXI_CACHE_W  = 4;
    localparam int unsigned AXI_PROT_W   = 3;
    localparam int unsigned AXI_QOS_W    = 4;
    localparam int unsigned AXI_REGION_W = 4;
    localparam int unsigned AXI_ATOP_W   = 6;
    localparam int unsigned AXI_RESP_W   = 2;

    typedef logic [AXI_LEN_W-1:0]    axi_len_t;
    typedef logic [AXI_SIZE_W-1:0]   axi_size_t;
    typedef logic [AXI_BURST_W-1:0]  axi_burst_t;
    typedef logic [AXI_CACHE_W-1:0]  axi_cache_t;
    typedef logic [AXI_PROT_W-1:0]   axi_prot_t;
    typedef logic [AXI_QOS_W-1:0]    axi_qos_t;
    typedef logic [AXI_REGION_W-1:0] axi_region_t;
    typedef logic [AXI_ATOP_W-1:0]   axi_atop_t;
    typedef logic [AXI_RESP_W-1:0]   axi_resp_t;

    localparam axi_size_t  AXI_SIZE_4B    = 3'b010;
    localparam axi_burst_t AXI_BURST_INCR = 2'b01;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    // Collapse the four AXI response codes onto a single APB error bit.
    function automatic logic resp_is_err(input axi_resp_t resp);
        logic err;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/apb_to_axi_master.sv
// Completes each APB transfer as one single-beat AXI4 transaction; one transfer
// outstanding, pready held low until the AXI response has been captured.
module apb_to_axi_master
    import apb_to_axi_master_pkg::*;
#(
    parameter int unsigned       APB_AW = 32,
    parameter int unsigned       APB_DW = 32,
    parameter int unsigned       AXI_AW = 64,
    parameter int unsigned       AXI_DW = 64,
    parameter int unsigned       AXI_IW = 1,
    parameter int unsigned       AXI_UW = 1,
    parameter logic [AXI_IW-1:0] AXI_ID = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // APB completer
    input  logic [APB_AW-1:0]     paddr,
    input  logic [APB_DW-1:0]     pwdata,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    output logic [APB_DW-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    // AXI write address
    output logic [AXI_IW-1:0]     aw_id,
    output logic [AXI_AW-1:0]     aw_addr,
    output axi_len_t              aw_len,
    output axi_size_t             aw_size,
    output axi_burst_t            aw_burst,
    output logic                  aw_lock,
    output axi_cache_t            aw_cache,
    output axi_prot_t             aw_prot,
    output axi_qos_t              aw_qos,
    output axi_region_t           aw_region,
    output axi_atop_t             aw_atop,
    output logic [AXI_UW-1:0]     aw_user,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    // AXI write data
    output logic [AXI_DW-1:0]     w_data,
    output logic [AXI_DW/8-1:0]   w_strb,
    output logic                  w_last,
    output logic [AXI_UW-1:0]     w_user,
    output logic                  w_valid,
    input  logic                  w_ready,
    // AXI write response
    input  axi_resp_t             b_resp,
    input  logic                  b_valid,
    output logic                  b_ready,
    // AXI read address
    output logic [AXI_IW-1:0]     ar_id,
    output logic [AXI_AW-1:0]     ar_addr,
    output axi_len_t              ar_len,
    output axi_size_t             ar_size,
    output axi_burst_t            ar_burst,
    output logic                  ar_lock,
    output axi_cache_t            ar_cache,
    output axi_prot_t             ar_prot,
    output axi_qos_t              ar_qos,
    output axi_region_t           ar_region,
    output logic [AXI_UW-1:0]     ar_user,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    // AXI read data
    input  logic [AXI_DW-1:0]     r_data,
    input  axi_resp_t             r_resp,
    input  logic                  r_valid,
    output logic                  r_ready
);

    localparam int unsigned STRB_W = AXI_DW / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_W = 3'd1,
        RESP_B = 3'd2,
        ADDR_R = 3'd3,
        RESP_R = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [APB_AW-1:0] addr_q,  addr_d;
    logic [AXI_DW-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [APB_DW-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              ar_valid_q, ar_valid_d;
    logic              b_ready_q, b_ready_d;
    logic              r_ready_q, r_ready_d;

    logic apb_access, misaligned;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_fin, w_fin;

    assign apb_access = psel && penable;
    assign misaligned = (paddr[1:0] != 2'b00);

    assign aw_hs = aw_valid_q && aw_ready;
    assign w_hs  = w_valid_q  && w_ready;
    assign b_hs  = b_ready_q  && b_valid;
    assign ar_hs = ar_valid_q && ar_ready;
    assign r_hs  = r_ready_q  && r_valid;

    // A channel is finished once its handshake happened now or in an earlier cycle.
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q  || w_hs;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; APB signals are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (apb_access) begin
                    if (misaligned) begin
                        state_d = DONE;
                    end else if (pwrite) begin
                        state_d = ADDR_W;
                    end else begin
                        state_d = ADDR_R;
                    end
                end
            end
            ADDR_W: if (aw_fin && w_fin) state_d = RESP_B;
            RESP_B: if (b_hs)            state_d = DONE;
            ADDR_R: if (ar_hs)           state_d = RESP_R;
            RESP_R: if (r_hs)            state_d = DONE;
            DONE:                        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Next values of every output register, derived from the upcoming state.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        prdata_d   = prdata_q;
        pslverr_d  = pslverr_q;

        pready_d   = (state_d == DONE);
        ar_valid_d = (state_d == ADDR_R);
        b_ready_d  = (state_d == RESP_B);
        r_ready_d  = (state_d == RESP_R);
        aw_done_d  = (state_d == ADDR_W) && aw_fin;
        w_done_d   = (state_d == ADDR_W) && w_fin;
        aw_valid_d = (state_d == ADDR_W) && !aw_fin;
        w_valid_d  = (state_d == ADDR_W) && !w_fin;

        if ((state_q == IDLE) && apb_access) begin
            addr_d  = paddr;
            wdata_d = AXI_DW'({pwdata, pwdata});
            wstrb_d = paddr[2] ? STRB_W'(8'hF0) : STRB_W'(8'h0F);
            if (misaligned) begin
                pslverr_d = 1'b1;
            end
        end

        if (b_hs) begin
            pslverr_d = resp_is_err(b_resp);
        end

        if (r_hs) begin
            prdata_d  = addr_q[2] ? r_data[AXI_DW-1 -: APB_DW] : r_data[APB_DW-1:0];
            pslverr_d = resp_is_err(r_resp);
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

    assign aw_id     = AXI_ID;
    assign aw_addr   = AXI_AW'(addr_q);
    assign aw_len    = '0;
    assign aw_size   = AXI_SIZE_4B;
    assign aw_burst  = AXI_BURST_INCR;
    assign aw_lock   = 1'b0;
    assign aw_cache  = '0;
    assign aw_prot   = '0;
    assign aw_qos    = '0;
    assign aw_region = '0;
    assign aw_atop   = '0;
    assign aw_user   = '0;
    assign aw_valid  = aw_valid_q;

    assign w_data  = wdata_q;
    assign w_strb  = wstrb_q;
    assign w_last  = 1'b1;
    assign w_user  = '0;
    assign w_valid = w_valid_q;

    assign b_ready = b_ready_q;

    assign ar_id     = AXI_ID;
    assign ar_addr   = AXI_AW'(addr_q);
    assign ar_len    = '0;
    assign ar_size   = AXI_SIZE_4B;
    assign ar_burst  = AXI_BURST_INCR;
    assign ar_lock   = 1'b0;
    assign ar_cache  = '0;
    assign ar_prot   = '0;
    assign ar_qos    = '0;
    assign ar_region = '0;
    assign ar_user   = '0;
    assign ar_valid  = ar_valid_q;

    assign r_ready = r_ready_q;

endmodule
